// File: rtl/csi2tx_payload_dw_buffer_if.sv
// Payload dword stream in, trimmed/enabled dword stream out, plus CRC and error status.
// The master side is the line source and consumer; the slave side is the buffer.
interface csi2tx_payload_dw_buffer_if;
    logic        line_start;
    logic [15:0] cfg_wc;
    logic [31:0] dw;
    logic        dw_vld;
    logic [31:0] out_dw;
    logic [3:0]  out_be;
    logic        out_last;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] crc_out;
    logic        crc_vld;
    logic        ovf_err;
    logic        len_err;
    logic        err_clr;

    modport master (
        output line_start, cfg_wc, dw, dw_vld, out_rdy, err_clr,
        input  out_dw, out_be, out_last, out_vld, crc_out, crc_vld, ovf_err, len_err
    );

    modport slave (
        input  line_start, cfg_wc, dw, dw_vld, out_rdy, err_clr,
        output out_dw, out_be, out_last, out_vld, crc_out, crc_vld, ovf_err, len_err
    );
endinterface

// File: rtl/csi2tx_payload_dw_buffer.sv
// Trims packed payload dwords to the line word count, accumulates CSI-2 CRC-16, buffers in a FIFO.
// Latency: dw_vld at N -> out_vld at N+1. Backpressure: out_rdy stalls the FIFO; a full FIFO drops writes (ovf_err).
module csi2tx_payload_dw_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    csi2tx_payload_dw_buffer_if.slave   bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]  state;
    logic [15:0] rem;
    logic [15:0] crc;
    logic        crc_vld_q;
    logic        ovf_q;
    logic        len_q;

    logic [36:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Reflected CCITT polynomial, one byte LSB-first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    logic [1:0]  eff_state;
    logic [15:0] eff_rem;
    logic [15:0] eff_crc;
    logic        accept;
    logic        last;
    logic [3:0]  be;
    logic [15:0] crc_next;
    logic        empty;
    logic        full;
    logic        rd_en;
    logic        wr_en;
    logic        drop;
    logic        len_set;

    // A line_start takes effect before the same-cycle dword is judged.
    always_comb begin
        eff_state = state;
        eff_rem   = rem;
        eff_crc   = crc;
        if (bus.line_start) begin
            eff_state = (bus.cfg_wc != 16'd0) ? ST_ACTIVE : ST_DONE;
            eff_rem   = bus.cfg_wc;
            eff_crc   = 16'hFFFF;
        end
    end

    always_comb begin
        accept = bus.dw_vld && (eff_state == ST_ACTIVE);
        last   = (eff_rem <= 16'd4);
        be     = 4'hF;
        if (last) begin
            be = 4'((5'd1 << eff_rem[2:0]) - 5'd1);
        end
        crc_next = eff_crc;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                crc_next = crc_byte(crc_next, bus.dw[8*i +: 8]);
            end
        end
    end

    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        rd_en   = !empty && bus.out_rdy;
        wr_en   = accept && (!full || rd_en);
        drop    = accept && full && !rd_en;
        len_set = (bus.line_start && (state == ST_ACTIVE)) ||
                  (bus.dw_vld && (eff_state != ST_ACTIVE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rem       <= 16'd0;
            crc       <= 16'hFFFF;
            crc_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
            len_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            if (accept) begin
                state <= last ? ST_DONE : eff_state;
                rem   <= last ? 16'd0 : (eff_rem - 16'd4);
                crc   <= crc_next;
            end else begin
                state <= eff_state;
                rem   <= eff_rem;
                crc   <= eff_crc;
            end

            if (accept && last) begin
                crc_vld_q <= 1'b1;
            end else if (bus.line_start) begin
                crc_vld_q <= (bus.cfg_wc == 16'd0);
            end

            // Clear wins over a same-cycle error event.
            if (bus.err_clr) begin
                ovf_q <= 1'b0;
                len_q <= 1'b0;
            end else begin
                ovf_q <= ovf_q | drop;
                len_q <= len_q | len_set;
            end

            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {last, be, bus.dw};
        end
    end

    logic [36:0] head;
    assign head = empty ? 37'd0 : mem[rd_ptr[AW-1:0]];

    assign bus.out_last = head[36];
    assign bus.out_be   = head[35:32];
    assign bus.out_dw   = head[31:0];
    assign bus.out_vld  = !empty;
    assign bus.crc_out  = crc;
    assign bus.crc_vld  = crc_vld_q;
    assign bus.ovf_err  = ovf_q;
    assign bus.len_err  = len_q;

endmodule

// File: tb/tb_csi2tx_payload_dw_buffer.sv
// Randomized and directed bench with a byte-level reference model and FIFO scoreboard.
module tb_csi2tx_payload_dw_buffer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csi2tx_payload_dw_buffer_if bus();

    csi2tx_payload_dw_buffer #(.DEPTH(16), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] dw;
        logic [3:0]  be;
        logic        last;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        exp_q[$];
    bit          m_active = 0;
    int          m_rem = 0;
    byte unsigned m_bytes[$];
    logic [15:0] m_crc = 16'hFFFF;
    bit          m_crc_vld = 0;
    bit          m_len = 0;
    bit          m_ovf = 0;
    bit          rdy_rand = 0;

    byte unsigned t1_bytes[24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                                   8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                                   8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial CRC over the whole line's enabled bytes.
    function automatic logic [15:0] ref_crc();
        logic [15:0] c;
        bit fb;
        c = 16'hFFFF;
        foreach (m_bytes[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ m_bytes[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_bytes.delete();
        m_active  = 0;
        m_rem     = 0;
        m_crc     = 16'hFFFF;
        m_crc_vld = 0;
        m_len     = 0;
        m_ovf     = 0;
    endfunction

    function automatic void model_step();
        bit   sl;
        bit   so;
        int   n;
        ent_t e;
        logic [31:0] d;
        sl = 0;
        so = 0;
        if (bus.line_start) begin
            if (m_active) sl = 1;
            m_rem = int'(bus.cfg_wc);
            m_bytes.delete();
            m_active  = (bus.cfg_wc != 0);
            m_crc_vld = (bus.cfg_wc == 0);
            if (bus.cfg_wc == 0) m_crc = 16'hFFFF;
        end
        if (bus.dw_vld) begin
            if (m_active) begin
                d = bus.dw;
                n = (m_rem < 4) ? m_rem : 4;
                for (int k = 0; k < n; k++) m_bytes.push_back(d[8*k +: 8]);
                e.dw   = d;
                e.be   = 4'((1 << n) - 1);
                e.last = (m_rem <= 4);
                m_rem  = m_rem - n;
                if (exp_q.size() < 16) exp_q.push_back(e);
                else so = 1;
                if (e.last) begin
                    m_active  = 0;
                    m_crc     = ref_crc();
                    m_crc_vld = 1;
                end
            end else begin
                sl = 1;
            end
        end
        if (bus.err_clr) begin
            m_len = 0;
            m_ovf = 0;
        end else begin
            m_len = m_len | sl;
            m_ovf = m_ovf | so;
        end
    endfunction

    // Monitor: compare state produced by past edges, then predict the coming edge.
    always @(negedge clk) begin
        chk("out_vld", bus.out_vld, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("out_dw", bus.out_dw, exp_q[0].dw);
            chk("out_be", bus.out_be, exp_q[0].be);
            chk("out_last", bus.out_last, exp_q[0].last);
        end else begin
            chk("out_idle", {bus.out_last, bus.out_be, bus.out_dw}, 0);
        end
        chk("crc_vld", bus.crc_vld, m_crc_vld);
        if (m_crc_vld) chk("crc_out", bus.crc_out, m_crc);
        chk("len_err", bus.len_err, m_len);
        chk("ovf_err", bus.ovf_err, m_ovf);
        if (rst) begin
            model_reset();
        end else begin
            if (exp_q.size() != 0 && bus.out_rdy) void'(exp_q.pop_front());
            model_step();
        end
    end

    task automatic cyc(input bit ls, input int wc, input bit v, input logic [31:0] d,
                       input bit clr, input bit r);
        bus.line_start = ls;
        bus.cfg_wc     = 16'(wc);
        bus.dw_vld     = v;
        bus.dw         = d;
        bus.err_clr    = clr;
        rst            = r;
        if (rdy_rand) bus.out_rdy = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
        bus.line_start = 0;
        bus.dw_vld     = 0;
        bus.err_clr    = 0;
        rst            = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0, 0, 0);
    endtask

    task automatic send(input logic [31:0] d);
        cyc(0, 0, 1, d, 0, 0);
    endtask

    initial begin
        int wc;
        int n;
        int k;
        rst            = 1;
        bus.line_start = 0;
        bus.cfg_wc     = 0;
        bus.dw         = 0;
        bus.dw_vld     = 0;
        bus.out_rdy    = 0;
        bus.err_clr    = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_crc_out", bus.crc_out, 16'hFFFF);
        chk("rst_crc_vld", bus.crc_vld, 0);

        // Known CSI-2 example line
        bus.out_rdy = 1;
        cyc(1, 24, 0, 32'd0, 0, 0);
        for (int i = 0; i < 6; i++)
            send({t1_bytes[4*i+3], t1_bytes[4*i+2], t1_bytes[4*i+1], t1_bytes[4*i]});
        idle(2);
        chk("t1_crc", bus.crc_out, 16'h00F0);
        chk("t1_crc_vld", bus.crc_vld, 1);

        // Partial final dword, line_start with first dword
        cyc(1, 10, 1, $urandom, 0, 0);
        send($urandom);
        send($urandom);
        idle(2);
        chk("t2_len_err", bus.len_err, 0);

        // Zero-length line
        cyc(1, 0, 0, 32'd0, 0, 0);
        idle(1);
        chk("t3_crc_vld", bus.crc_vld, 1);
        chk("t3_crc", bus.crc_out, 16'hFFFF);
        chk("t3_out_vld", bus.out_vld, 0);

        // Overflow, then write on a full-but-reading cycle
        bus.out_rdy = 0;
        cyc(1, 80, 0, 32'd0, 0, 0);
        for (int i = 0; i < 20; i++) send($urandom);
        chk("t4_ovf", bus.ovf_err, 1);
        cyc(0, 0, 0, 32'd0, 1, 0);
        chk("t4_ovf_clr", bus.ovf_err, 0);
        cyc(1, 8, 0, 32'd0, 0, 0);
        bus.out_rdy = 1;
        send($urandom);
        send($urandom);
        idle(20);
        chk("t4_no_ovf", bus.ovf_err, 0);

        // Short line, stray dword, clear priority
        cyc(1, 16, 0, 32'd0, 0, 0);
        send($urandom);
        send($urandom);
        cyc(1, 16, 1, $urandom, 0, 0);
        for (int i = 0; i < 3; i++) send($urandom);
        send($urandom);
        idle(1);
        chk("t5_len_err", bus.len_err, 1);
        cyc(0, 0, 0, 32'd0, 1, 0);
        chk("t5_len_clr", bus.len_err, 0);
        cyc(0, 0, 1, $urandom, 1, 0);
        chk("t5_clr_prio", bus.len_err, 0);

        // Reset mid-line
        bus.out_rdy = 0;
        cyc(1, 40, 0, 32'd0, 0, 0);
        for (int i = 0; i < 5; i++) send($urandom);
        cyc(0, 0, 0, 32'd0, 0, 1);
        chk("t6_out_vld", bus.out_vld, 0);
        chk("t6_crc_vld", bus.crc_vld, 0);
        send($urandom);
        chk("t6_idle_drop", bus.len_err, 1);
        cyc(0, 0, 0, 32'd0, 1, 0);

        // Random lines with random backpressure
        rdy_rand = 1;
        for (int l = 0; l < 40; l++) begin
            wc = $urandom_range(0, 48);
            n  = (wc + 3) / 4;
            if ($urandom_range(0, 7) == 0) n = n + 1;
            if ($urandom_range(0, 7) == 0 && n > 1) n = n - 1;
            if (n > 0 && $urandom_range(0, 1) == 1) begin
                cyc(1, wc, 1, $urandom, 0, 0);
                k = 1;
            end else begin
                cyc(1, wc, 0, 32'd0, 0, 0);
                k = 0;
            end
            while (k < n) begin
                repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 32'd0, $urandom_range(0, 15) == 0, 0);
                send($urandom);
                k++;
            end
        end
        rdy_rand    = 0;
        bus.out_rdy = 1;
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
